trap_sequencer: RTL and testbench

Trap-entry and MRET sequencer sitting directly upstream of the CSR register file. It owns that file's single write port and its read address. In idle it passes the pipeline's CSR-instruction writes straight through. On a trap or MRET it stalls the pipeline, performs the machine-mode CSR updates one write per cycle, then issues a one-cycle PC redirect to `mtvec` or `mepc`.

---
 rtl/trap_sequencer.sv | 209 ++++++++++++++++++++
 tb/tb_trap_sequencer.sv | 328 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/trap_sequencer.sv
// -----------------------------------------------------------------------------
// trap_sequencer
//
// Purpose:
//   Trap-entry / MRET sequencer placed directly in front of the CSR register
//   file. It owns the file's single write port and its read address. In IDLE,
//   pipeline CSR writes and reads pass straight through. On a trap it stalls
//   the pipeline and writes mepc, mcause, mtval and mstatus on consecutive
//   cycles, then strobes a PC redirect to mtvec. On MRET it rewrites mstatus,
//   then strobes a PC redirect to mepc.
//
// Optional feature:
//   TRAP_VECTORED_EN - when defined, interrupts taken with mtvec[1:0]==2'b01
//                      jump to BASE + 4*cause. When undefined, the target is
//                      always the direct-mode BASE (mtvec[1:0] ignored).
//
// Ports:
//   clk, rst_n              clock (rising edge), async active-low reset
//   pipe_we/waddr/wdata     pipeline CSR write request (ignored while busy)
//   pipe_raddr              pipeline CSR read address (used only in IDLE)
//   trap_req                single-cycle trap pulse with cause/pc/tval
//   trap_cause/pc/tval      trap information, latched on acceptance
//   mret_req                single-cycle MRET pulse
//   csr_rdata               combinational read data from the CSR file
//   csr_raddr               CSR file read address
//   csr_we/waddr/wdata      CSR file write port
//   busy                    pipeline stall, high whenever not IDLE
//   redirect_valid          one-cycle PC redirect strobe
//   redirect_pc             redirect target (word aligned, 0 when no strobe)
//   dbg_state               current FSM state, for observation only
//
// Handshake: there is no back-pressure. Requests are accepted only in a
// cycle where busy==0; requests presented while busy==1 are dropped. The
// redirect is a single-cycle strobe that the consumer must take when seen.
// -----------------------------------------------------------------------------
package trap_sequencer_pkg;
    typedef enum logic {
        REG_NO_WE = 1'b0,
        REG_WE    = 1'b1
    } reg_we_e;
endpackage

module trap_sequencer
    import trap_sequencer_pkg::*;
#(
    parameter logic [11:0] MTVEC_ADDR   = 12'h305,
    parameter logic [11:0] MEPC_ADDR    = 12'h341,
    parameter logic [11:0] MCAUSE_ADDR  = 12'h342,
    parameter logic [11:0] MTVAL_ADDR   = 12'h343,
    parameter logic [11:0] MSTATUS_ADDR = 12'h300
) (
    input  logic        clk,
    input  logic        rst_n,
    input  reg_we_e     pipe_we,
    input  logic [11:0] pipe_waddr,
    input  logic [31:0] pipe_wdata,
    input  logic [11:0] pipe_raddr,
    input  logic        trap_req,
    input  logic [31:0] trap_cause,
    input  logic [31:0] trap_pc,
    input  logic [31:0] trap_tval,
    input  logic        mret_req,
    input  logic [31:0] csr_rdata,
    output logic [11:0] csr_raddr,
    output reg_we_e     csr_we,
    output logic [11:0] csr_waddr,
    output logic [31:0] csr_wdata,
    output logic        busy,
    output logic        redirect_valid,
    output logic [31:0] redirect_pc,
    output logic [2:0]  dbg_state
);

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        T_MEPC    = 3'd1,
        T_MCAUSE  = 3'd2,
        T_MTVAL   = 3'd3,
        T_MSTATUS = 3'd4,
        T_JUMP    = 3'd5,
        R_MSTATUS = 3'd6,
        R_JUMP    = 3'd7
    } state_e;

    state_e      r_state;
    state_e      w_next;
    logic        w_latch;
    logic [31:0] r_cause;
    logic [31:0] r_pc;
    logic [31:0] r_tval;
    logic [31:0] w_base;

    // Direct-mode target: the CSR value with its mode bits dropped.
    assign w_base    = {csr_rdata[31:2], 2'b00};
    assign dbg_state = r_state;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
            r_cause <= 32'd0;
            r_pc    <= 32'd0;
            r_tval  <= 32'd0;
        end else begin
            r_state <= w_next;
            if (w_latch) begin
                r_cause <= trap_cause;
                r_pc    <= trap_pc;
                r_tval  <= trap_tval;
            end
        end
    end

    always_comb begin
        w_next         = r_state;
        w_latch        = 1'b0;
        csr_raddr      = pipe_raddr;
        csr_we         = REG_NO_WE;
        csr_waddr      = 12'd0;
        csr_wdata      = 32'd0;
        busy           = 1'b1;
        redirect_valid = 1'b0;
        redirect_pc    = 32'd0;

        case (r_state)
            IDLE: begin
                busy      = 1'b0;
                csr_we    = pipe_we;
                csr_waddr = pipe_waddr;
                csr_wdata = pipe_wdata;
                if (trap_req) begin
                    // Faulting instruction does not retire: drop its write.
                    csr_we  = REG_NO_WE;
                    w_latch = 1'b1;
                    w_next  = T_MEPC;
                end else if (mret_req) begin
                    w_next = R_MSTATUS;
                end
            end
            T_MEPC: begin
                csr_we    = REG_WE;
                csr_waddr = MEPC_ADDR;
                csr_wdata = r_pc & 32'hFFFF_FFFC;
                w_next    = T_MCAUSE;
            end
            T_MCAUSE: begin
                csr_we    = REG_WE;
                csr_waddr = MCAUSE_ADDR;
                csr_wdata = r_cause;
                w_next    = T_MTVAL;
            end
            T_MTVAL: begin
                csr_we    = REG_WE;
                csr_waddr = MTVAL_ADDR;
                csr_wdata = r_tval;
                w_next    = T_MSTATUS;
            end
            T_MSTATUS: begin
                // Read-modify-write in one cycle: MPIE<-MIE, MIE<-0, MPP<-M.
                csr_raddr         = MSTATUS_ADDR;
                csr_we            = REG_WE;
                csr_waddr         = MSTATUS_ADDR;
                csr_wdata         = csr_rdata;
                csr_wdata[7]      = csr_rdata[3];
                csr_wdata[3]      = 1'b0;
                csr_wdata[12:11]  = 2'b11;
                w_next            = T_JUMP;
            end
            T_JUMP: begin
                csr_raddr      = MTVEC_ADDR;
                redirect_valid = 1'b1;
                redirect_pc    = w_base;
`ifdef TRAP_VECTORED_EN
                // Vectored interrupts: BASE + 4*cause, modulo 2^32.
                if ((csr_rdata[1:0] == 2'b01) && r_cause[31]) begin
                    redirect_pc = w_base + {r_cause[29:0], 2'b00};
                end
`endif
                w_next = IDLE;
            end
            R_MSTATUS: begin
                // MIE<-MPIE, MPIE<-1, MPP stays machine mode.
                csr_raddr         = MSTATUS_ADDR;
                csr_we            = REG_WE;
                csr_waddr         = MSTATUS_ADDR;
                csr_wdata         = csr_rdata;
                csr_wdata[3]      = csr_rdata[7];
                csr_wdata[7]      = 1'b1;
                csr_wdata[12:11]  = 2'b11;
                w_next            = R_JUMP;
            end
            R_JUMP: begin
                csr_raddr      = MEPC_ADDR;
                redirect_valid = 1'b1;
                redirect_pc    = w_base;
                w_next         = IDLE;
            end
            default: begin
                w_next = IDLE;
            end
        endcase

        // The write port must stay quiet while reset is held, whatever
        // the pipeline is presenting.
        if (!rst_n) begin
            csr_we = REG_NO_WE;
        end
    end

endmodule

// File: tb/tb_trap_sequencer.sv
module tb_trap_sequencer;
  import trap_sequencer_pkg::*;

  // ---------------- clock / reset ----------------
  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  always #5 clk = ~clk;

  reg_we_e     pipe_we = REG_NO_WE;
  logic [11:0] pipe_waddr = 12'd0;
  logic [31:0] pipe_wdata = 32'd0;
  logic [11:0] pipe_raddr = 12'd0;
  logic        trap_req = 1'b0;
  logic [31:0] trap_cause = 32'd0;
  logic [31:0] trap_pc = 32'd0;
  logic [31:0] trap_tval = 32'd0;
  logic        mret_req = 1'b0;
  logic [31:0] csr_rdata;
  logic [11:0] csr_raddr;
  reg_we_e     csr_we;
  logic [11:0] csr_waddr;
  logic [31:0] csr_wdata;
  logic        busy;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic [2:0]  dbg_state;

  int checks = 0;
  int errors = 0;

  // Behavioural CSR file: combinational read, write on rising edge.
  logic [31:0] csr_mem [0:4095];
  assign csr_rdata = csr_mem[csr_raddr];
  always @(posedge clk) begin
    if (csr_we == REG_WE) csr_mem[csr_waddr] <= csr_wdata;
  end

  trap_sequencer dut (
    .clk(clk), .rst_n(rst_n),
    .pipe_we(pipe_we), .pipe_waddr(pipe_waddr), .pipe_wdata(pipe_wdata),
    .pipe_raddr(pipe_raddr),
    .trap_req(trap_req), .trap_cause(trap_cause), .trap_pc(trap_pc),
    .trap_tval(trap_tval), .mret_req(mret_req),
    .csr_rdata(csr_rdata), .csr_raddr(csr_raddr), .csr_we(csr_we),
    .csr_waddr(csr_waddr), .csr_wdata(csr_wdata),
    .busy(busy), .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .dbg_state(dbg_state)
  );

  // ---------------- driver helpers ----------------
  // Inputs change 1 time unit after the rising edge; outputs are sampled
  // mid-cycle on the falling edge.
  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic mid();
    #4;
  endtask

  task automatic preload(input logic [11:0] a, input logic [31:0] d);
    cyc();
    pipe_we = REG_WE;
    pipe_waddr = a;
    pipe_wdata = d;
    cyc();
    pipe_we = REG_NO_WE;
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    rst_n = 1'b0;
    pipe_we = REG_WE;
    pipe_waddr = 12'h340;
    pipe_wdata = 32'h1111_1111;
    #12;
    checks++;
    if (csr_we !== REG_NO_WE) begin
      errors++; $display("FAIL reset_we: got %0d want 0", csr_we);
    end
    checks++;
    if (busy !== 1'b0 || redirect_valid !== 1'b0 || redirect_pc !== 32'd0) begin
      errors++;
      $display("FAIL reset_outs: busy=%0b rv=%0b pc=%h want 0/0/0", busy, redirect_valid, redirect_pc);
    end
    pipe_we = REG_NO_WE;
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_passthrough();
    cyc();
    pipe_we = REG_WE;
    pipe_waddr = 12'h340;
    pipe_wdata = 32'hDEAD_BEEF;
    pipe_raddr = 12'h305;
    mid();
    checks++;
    if (csr_we !== REG_WE || csr_waddr !== 12'h340 || csr_wdata !== 32'hDEAD_BEEF) begin
      errors++;
      $display("FAIL pass_write: we=%0d a=%h d=%h want 1/340/deadbeef", csr_we, csr_waddr, csr_wdata);
    end
    checks++;
    if (csr_raddr !== 12'h305 || busy !== 1'b0 || redirect_valid !== 1'b0) begin
      errors++;
      $display("FAIL pass_misc: raddr=%h busy=%0b rv=%0b want 305/0/0", csr_raddr, busy, redirect_valid);
    end
    cyc();
    pipe_we = REG_NO_WE;
  endtask

  task automatic test_trap();
    reg_we_e     ew [5] = '{REG_WE, REG_WE, REG_WE, REG_WE, REG_NO_WE};
    logic [11:0] ea [5] = '{12'h341, 12'h342, 12'h343, 12'h300, 12'h000};
    logic [31:0] ed [5] = '{32'h1004, 32'h2, 32'h1234, 32'h1880, 32'h0};
    preload(12'h305, 32'h0000_0103);
    preload(12'h300, 32'h0000_0008);
    cyc();
    trap_req = 1'b1;
    trap_cause = 32'h2;
    trap_pc = 32'h0000_1006;
    trap_tval = 32'h1234;
    pipe_we = REG_WE;          // must be suppressed, and ignored while busy
    pipe_waddr = 12'h340;
    pipe_wdata = 32'h5A5A_5A5A;
    mid();
    checks++;
    if (csr_we !== REG_NO_WE || busy !== 1'b0) begin
      errors++; $display("FAIL trap_accept: we=%0d busy=%0b want 0/0", csr_we, busy);
    end
    for (int k = 0; k < 5; k++) begin
      cyc();
      trap_req = 1'b0;
      mid();
      checks++;
      if (busy !== 1'b1 || csr_we !== ew[k]) begin
        errors++; $display("FAIL trap_step%0d: busy=%0b we=%0d want 1/%0d", k, busy, csr_we, ew[k]);
      end
      if (ew[k] == REG_WE) begin
        checks++;
        if (csr_waddr !== ea[k] || csr_wdata !== ed[k]) begin
          errors++;
          $display("FAIL trap_write%0d: a=%h d=%h want %h/%h", k, csr_waddr, csr_wdata, ea[k], ed[k]);
        end
      end
      checks++;
      if (redirect_valid !== (k == 4)) begin
        errors++; $display("FAIL trap_rv%0d: got %0b want %0b", k, redirect_valid, (k == 4));
      end
    end
    checks++;
    if (redirect_pc !== 32'h0000_0100) begin
      errors++; $display("FAIL trap_target: got %h want 00000100", redirect_pc);
    end
    cyc();
    pipe_we = REG_NO_WE;
    mid();
    checks++;
    if (busy !== 1'b0 || redirect_valid !== 1'b0) begin
      errors++; $display("FAIL trap_done: busy=%0b rv=%0b want 0/0", busy, redirect_valid);
    end
    checks++;
    if (csr_mem[12'h341] !== 32'h1004 || csr_mem[12'h300] !== 32'h1880) begin
      errors++;
      $display("FAIL trap_mem: mepc=%h mstatus=%h want 1004/1880", csr_mem[12'h341], csr_mem[12'h300]);
    end
  endtask

  task automatic test_mret();
    preload(12'h300, 32'h0000_1880);
    preload(12'h341, 32'h0000_2000);
    cyc();
    mret_req = 1'b1;
    pipe_we = REG_WE;
    pipe_waddr = 12'h340;
    pipe_wdata = 32'h77;
    mid();
    checks++;
    if (csr_we !== REG_WE || csr_waddr !== 12'h340 || busy !== 1'b0) begin
      errors++; $display("FAIL mret_pass: we=%0d a=%h busy=%0b want 1/340/0", csr_we, csr_waddr, busy);
    end
    cyc();
    mret_req = 1'b0;
    pipe_we = REG_NO_WE;
    mid();
    checks++;
    if (busy !== 1'b1 || csr_we !== REG_WE || csr_waddr !== 12'h300 || csr_wdata !== 32'h1888) begin
      errors++;
      $display("FAIL mret_mstatus: busy=%0b we=%0d a=%h d=%h want 1/1/300/1888", busy, csr_we, csr_waddr, csr_wdata);
    end
    cyc();
    mid();
    checks++;
    if (busy !== 1'b1 || redirect_valid !== 1'b1 || redirect_pc !== 32'h2000 || csr_we !== REG_NO_WE) begin
      errors++;
      $display("FAIL mret_jump: busy=%0b rv=%0b pc=%h we=%0d want 1/1/2000/0", busy, redirect_valid, redirect_pc, csr_we);
    end
    cyc();
    mid();
    checks++;
    if (busy !== 1'b0 || redirect_valid !== 1'b0) begin
      errors++; $display("FAIL mret_done: busy=%0b rv=%0b want 0/0", busy, redirect_valid);
    end
  endtask

  task automatic test_collision();
    cyc();
    trap_req = 1'b1;
    mret_req = 1'b1;
    trap_cause = 32'h3;
    trap_pc = 32'h0000_4000;
    trap_tval = 32'h0;
    pipe_we = REG_WE;
    pipe_waddr = 12'h340;
    pipe_wdata = 32'h99;
    mid();
    checks++;
    if (csr_we !== REG_NO_WE) begin
      errors++; $display("FAIL coll_we: got %0d want 0", csr_we);
    end
    cyc();
    trap_req = 1'b0;
    mret_req = 1'b0;
    pipe_we = REG_NO_WE;
    mid();
    checks++;
    if (csr_waddr !== 12'h341 || csr_wdata !== 32'h4000 || dbg_state !== 3'd1) begin
      errors++;
      $display("FAIL coll_trap: a=%h d=%h st=%0d want 341/4000/1", csr_waddr, csr_wdata, dbg_state);
    end
    for (int k = 0; k < 4; k++) cyc();
    cyc();
    mid();
    checks++;
    if (busy !== 1'b0 || dbg_state !== 3'd0) begin
      errors++; $display("FAIL coll_idle: busy=%0b st=%0d want 0/0", busy, dbg_state);
    end
    cyc();
    mid();
    checks++;
    if (busy !== 1'b0) begin
      errors++; $display("FAIL coll_mret_dropped: busy=%0b want 0", busy);
    end
  endtask

  task automatic test_vectored();
    logic [31:0] exp_pc;
`ifdef TRAP_VECTORED_EN
    exp_pc = 32'h0000_011C;
`else
    exp_pc = 32'h0000_0100;
`endif
    preload(12'h305, 32'h0000_0101);
    cyc();
    trap_req = 1'b1;
    trap_cause = 32'h8000_0007;
    trap_pc = 32'h0000_0500;
    trap_tval = 32'h0000_AAAA;
    for (int k = 0; k < 5; k++) begin
      cyc();
      trap_req = 1'b0;
    end
    mid();
    checks++;
    if (redirect_valid !== 1'b1 || redirect_pc !== exp_pc) begin
      errors++; $display("FAIL vec_target: rv=%0b pc=%h want 1/%h", redirect_valid, redirect_pc, exp_pc);
    end
    cyc();
  endtask

  task automatic test_reset_mid();
    int rv_seen = 0;
    cyc();
    trap_req = 1'b1;
    trap_cause = 32'h5;
    trap_pc = 32'h0000_3002;
    trap_tval = 32'h0000_5555;
    cyc();                  // T_MEPC
    trap_req = 1'b0;
    cyc();                  // T_MCAUSE
    cyc();                  // T_MTVAL: mepc and mcause are committed
    rst_n = 1'b0;
    #1;
    checks++;
    if (busy !== 1'b0 || redirect_valid !== 1'b0 || csr_we !== REG_NO_WE) begin
      errors++;
      $display("FAIL rstmid_now: busy=%0b rv=%0b we=%0d want 0/0/0", busy, redirect_valid, csr_we);
    end
    cyc();
    rst_n = 1'b1;
    for (int k = 0; k < 6; k++) begin
      mid();
      if (redirect_valid !== 1'b0 || busy !== 1'b0) rv_seen++;
      cyc();
    end
    checks++;
    if (rv_seen != 0) begin
      errors++; $display("FAIL rstmid_after: %0d cycles busy/redirect, want 0", rv_seen);
    end
    checks++;
    if (csr_mem[12'h341] !== 32'h3000 || csr_mem[12'h342] !== 32'h5 || csr_mem[12'h343] !== 32'hAAAA) begin
      errors++;
      $display("FAIL rstmid_mem: mepc=%h mcause=%h mtval=%h want 3000/5/aaaa",
               csr_mem[12'h341], csr_mem[12'h342], csr_mem[12'h343]);
    end
  endtask

  // ---------------- sequence + report ----------------
  initial begin
    test_reset();
    test_passthrough();
    test_trap();
    test_mret();
    test_collision();
    test_vectored();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1);
  end

endmodule
